alu_operand_stage: RTL and testbench

//  Operand-fetch pipeline stage directly upstream of the RV32I integer ALU.
//  - Accepts one 32-bit OP/OP-IMM instruction per handshake and decodes funct3, funct7, opImm and immediateI.
//  - Reads rs1/rs2 from an internal 31x32 register file (x0 hardwired to 0) and registers everything toward the ALU.
//  - Takes the ALU writeback port back in, and forwards writes into both new reads and held operands.

---
 rtl/alu_operand_stage.sv | 154 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the RV32I ALU: decodes OP/OP-IMM words, reads the
// 31x32 register file with write-through bypass, and keeps held operands coherent with writeback.
module alu_operand_stage #(
    parameter bit CLEAR_REGFILE_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instructionValid,
    output logic        instructionReady,
    input  logic [31:0] instruction,
    input  logic        rdWriteEnable,
    input  logic [4:0]  rdWriteAddress,
    input  logic [31:0] rdWriteData,
    output logic        outValid,
    input  logic        outReady,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        opImm,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic [31:0] immediateI,
    output logic [4:0]  rdAddress,
    output logic        illegalInstruction
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned NREG = 32;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [XLEN-1:0] rf [NREG];
    logic [REGW-1:0] rs1_idx;
    logic [REGW-1:0] rs2_idx;

    logic [6:0]      dec_opcode;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;
    logic [REGW-1:0] dec_rs1;
    logic [REGW-1:0] dec_rs2;
    logic [REGW-1:0] dec_rd;
    logic            dec_opimm;
    logic            dec_legal;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;
    logic            accept;
    logic            hold;
    logic            wr_hit;

    assign instructionReady = ~outValid | outReady;
    assign accept           = instructionValid & instructionReady;
    assign hold             = outValid & ~outReady;
    assign wr_hit           = rdWriteEnable & (rdWriteAddress != '0);

    // Field extraction and OP/OP-IMM legality
    always_comb begin
        dec_opcode = instruction[6:0];
        dec_rd     = instruction[11:7];
        dec_funct3 = instruction[14:12];
        dec_rs1    = instruction[19:15];
        dec_rs2    = instruction[24:20];
        dec_funct7 = instruction[31:25];
        dec_opimm  = (dec_opcode == OPC_OP_IMM);
        dec_legal  = 1'b0;
        if (dec_opimm) begin
            case (dec_funct3)
                3'b001:  dec_legal = (dec_funct7 == F7_ZERO);
                3'b101:  dec_legal = (dec_funct7 == F7_ZERO) || (dec_funct7 == F7_ALT);
                default: dec_legal = 1'b1;
            endcase
        end else if (dec_opcode == OPC_OP) begin
            dec_legal = (dec_funct7 == F7_ZERO) ||
                        ((dec_funct7 == F7_ALT) && ((dec_funct3 == 3'b000) || (dec_funct3 == 3'b101)));
        end
    end

    // Register file read with same-cycle writeback bypass; x0 reads as zero
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        if (dec_rs1 != '0) begin
            rd1_c = (wr_hit && (rdWriteAddress == dec_rs1)) ? rdWriteData : rf[dec_rs1];
        end
        if ((dec_rs2 != '0) && !dec_opimm) begin
            rd2_c = (wr_hit && (rdWriteAddress == dec_rs2)) ? rdWriteData : rf[dec_rs2];
        end
    end

    if (CLEAR_REGFILE_ON_RESET) begin : g_rf_clear
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < int'(NREG); i++) begin
                    rf[i] <= '0;
                end
            end else if (wr_hit) begin
                rf[rdWriteAddress] <= rdWriteData;
            end
        end
    end else begin : g_rf_keep
        always_ff @(posedge clock) begin
            if (wr_hit) begin
                rf[rdWriteAddress] <= rdWriteData;
            end
        end
    end

    // Single output register toward the ALU; held operands track writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid           <= 1'b0;
            illegalInstruction <= 1'b0;
            funct3             <= '0;
            funct7             <= '0;
            opImm              <= 1'b0;
            rs1                <= '0;
            rs2                <= '0;
            immediateI         <= '0;
            rdAddress          <= '0;
            rs1_idx            <= '0;
            rs2_idx            <= '0;
        end else begin
            illegalInstruction <= accept & ~dec_legal;
            if (accept) begin
                outValid <= dec_legal;
                if (dec_legal) begin
                    funct3     <= dec_funct3;
                    funct7     <= dec_funct7;
                    opImm      <= dec_opimm;
                    rs1        <= rd1_c;
                    rs2        <= rd2_c;
                    immediateI <= {{(XLEN-12){instruction[31]}}, instruction[31:20]};
                    rdAddress  <= dec_rd;
                    rs1_idx    <= dec_rs1;
                    rs2_idx    <= dec_rs2;
                end
            end else begin
                if (outReady) begin
                    outValid <= 1'b0;
                end
                if (hold && wr_hit) begin
                    if (rdWriteAddress == rs1_idx) begin
                        rs1 <= rdWriteData;
                    end
                    if (!opImm && (rdWriteAddress == rs2_idx)) begin
                        rs2 <= rdWriteData;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: reference regfile plus expected-bundle queue.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        instructionValid;
    logic        instructionReady;
    logic [31:0] instruction;
    logic        rdWriteEnable;
    logic [4:0]  rdWriteAddress;
    logic [31:0] rdWriteData;
    logic        outValid;
    logic        outReady;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        opImm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] immediateI;
    logic [4:0]  rdAddress;
    logic        illegalInstruction;

    alu_operand_stage #(.CLEAR_REGFILE_ON_RESET(1'b1)) dut (
        .clock              (clock),
        .reset              (reset),
        .instructionValid   (instructionValid),
        .instructionReady   (instructionReady),
        .instruction        (instruction),
        .rdWriteEnable      (rdWriteEnable),
        .rdWriteAddress     (rdWriteAddress),
        .rdWriteData        (rdWriteData),
        .outValid           (outValid),
        .outReady           (outReady),
        .funct3             (funct3),
        .funct7             (funct7),
        .opImm              (opImm),
        .rs1                (rs1),
        .rs2                (rs2),
        .immediateI         (immediateI),
        .rdAddress          (rdAddress),
        .illegalInstruction (illegalInstruction)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        opimm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  s1;
        logic [4:0]  s2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf [32];
    logic        m_valid;
    logic        m_ill;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] b,
                                          input logic [4:0] a, input logic [2:0] f3, input logic [4:0] d);
        return {f7, b, a, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] a,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, a, f3, d, 7'b0010011};
    endfunction

    function automatic logic is_legal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h13: begin
                if (f3 == 3'b001) return f7 == 7'h00;
                if (f3 == 3'b101) return (f7 == 7'h00) || (f7 == 7'h20);
                return 1'b1;
            end
            7'h33: begin
                case (f7)
                    7'h00:   return 1'b1;
                    7'h20:   return (f3 == 3'b000) || (f3 == 3'b101);
                    default: return 1'b0;
                endcase
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input bit legal_only);
        logic [6:0]  f7;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  a, b, d;
        logic [31:0] ins;
        f3 = 3'($urandom_range(0, 7));
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = legal_only ? 7'h00 : 7'($urandom);
        endcase
        opc = ($urandom_range(0, 1) == 1) ? 7'b0010011 : 7'b0110011;
        if (!legal_only && ($urandom_range(0, 7) == 0)) opc = 7'($urandom);
        ins = {f7, b, a, f3, d, opc};
        if (legal_only && !is_legal(ins)) ins = {7'h00, b, a, f3, d, opc};
        return ins;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && (wa == idx)) return wd;
        return mrf[idx];
    endfunction

    // One clock of stimulus; called right after a falling edge
    task automatic step(input logic iv, input logic [31:0] ins, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        exp_t e;
        logic acc;
        logic lg;
        instructionValid = iv;
        instruction      = ins;
        rdWriteEnable    = we;
        rdWriteAddress   = wa;
        rdWriteData      = wd;
        outReady         = ordy;
        #1;
        check("ready", 32'(instructionReady), 32'(!m_valid | ordy));
        check("out_valid", 32'(outValid), 32'(m_valid));
        check("illegal", 32'(illegalInstruction), 32'(m_ill));
        if (m_valid) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
                check("funct3", 32'(funct3), 32'(sb[0].f3));
                check("funct7", 32'(funct7), 32'(sb[0].f7));
                check("opimm", 32'(opImm), 32'(sb[0].opimm));
                check("rs1", rs1, sb[0].rs1);
                check("rs2", rs2, sb[0].rs2);
                check("imm", immediateI, sb[0].imm);
                check("rd", 32'(rdAddress), 32'(sb[0].rd));
                if (ordy) begin
                    void'(sb.pop_front());
                end else if (we && (wa != 5'd0)) begin
                    if (wa == sb[0].s1) sb[0].rs1 = wd;
                    if (!sb[0].opimm && (wa == sb[0].s2)) sb[0].rs2 = wd;
                end
            end
        end
        acc   = iv & (!m_valid | ordy);
        lg    = is_legal(ins);
        m_ill = acc & !lg;
        if (acc && lg) begin
            e.f3    = ins[14:12];
            e.f7    = ins[31:25];
            e.opimm = (ins[6:0] == 7'h13);
            e.s1    = ins[19:15];
            e.s2    = ins[24:20];
            e.rd    = ins[11:7];
            e.imm   = {{20{ins[31]}}, ins[31:20]};
            e.rs1   = model_read(e.s1, we, wa, wd);
            e.rs2   = e.opimm ? 32'd0 : model_read(e.s2, we, wa, wd);
            sb.push_back(e);
        end
        if (we && (wa != 5'd0)) mrf[wa] = wd;
        if (acc && lg)   m_valid = 1'b1;
        else if (ordy)   m_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_model();
        sb.delete();
        m_valid = 1'b0;
        m_ill   = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    endtask

    initial begin
        reset            = 1'b1;
        instructionValid = 1'b0;
        instruction      = 32'd0;
        rdWriteEnable    = 1'b0;
        rdWriteAddress   = 5'd0;
        rdWriteData      = 32'd0;
        outReady         = 1'b0;
        clear_model();
        repeat (2) @(negedge clock);
        check("rst_out_valid", 32'(outValid), 32'd0);
        check("rst_illegal", 32'(illegalInstruction), 32'd0);
        check("rst_rs1", rs1, 32'd0);
        check("rst_imm", immediateI, 32'd0);
        check("rst_rd", 32'(rdAddress), 32'd0);
        reset = 1'b0;

        // add x3,x1,x2 straight out of reset
        step(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 5'd0, 32'd0, 1'b1);
        // addi x4,x1,-1 with x1=5 written the same cycle
        step(1'b1, i_type(12'hfff, 5'd1, 3'b000, 5'd4), 1'b1, 5'd1, 32'd5, 1'b1);
        step(1'b0, 32'd0, 1'b1, 5'd6, 32'h0000_0011, 1'b1);
        // sub x5,x6,x7 held while x7 is written
        step(1'b1, r_type(7'h20, 5'd7, 5'd6, 3'b000, 5'd5), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, r_type(7'h00, 5'd1, 5'd1, 3'b111, 5'd9), 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, r_type(7'h00, 5'd1, 5'd1, 3'b111, 5'd9), 1'b1, 5'd7, 32'hdead_beef, 1'b0);
        step(1'b0, 32'd0, 1'b1, 5'd6, 32'h0000_0022, 1'b0);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        // x0 write ignored, then or x1,x0,x0
        step(1'b0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b1);
        step(1'b1, r_type(7'h00, 5'd0, 5'd0, 3'b110, 5'd1), 1'b0, 5'd0, 32'd0, 1'b1);
        // ecall and an illegal sub-variant, each followed by a legal word
        step(1'b1, 32'h0000_0073, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, r_type(7'h00, 5'd7, 5'd1, 3'b100, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, r_type(7'h20, 5'd7, 5'd1, 3'b001, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, i_type(12'h405, 5'd7, 3'b101, 5'd8), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, i_type(12'h401, 5'd7, 3'b001, 5'd8), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

        // eight back-to-back legal words
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rand_instr(1'b1), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, 1'b1);
        end

        // random traffic with backpressure, writeback and illegal words
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(1'b0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) != 0));
        end

        // reset while a bundle is held
        step(1'b0, 32'd0, 1'b1, 5'd3, 32'h0000_0abc, 1'b1);
        step(1'b1, r_type(7'h00, 5'd4, 5'd3, 3'b000, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("pre_rst_valid", 32'(outValid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(outValid), 32'd0);
        check("async_rst_rs1", rs1, 32'd0);
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, r_type(7'h00, 5'd4, 5'd3, 3'b000, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
